// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request per PC, result held for decode,
// PC advance pulsed on decode accept, flush discards any in-flight response.
//
// state | meaning
// IDLE  | latch pc_in; misaligned PC faults straight to HOLD, else request it
// REQ   | imem request presented until accepted
// WAIT  | request accepted, waiting for the response
// HOLD  | instruction presented to decode until accepted or flushed
// DROP  | accepted request was flushed; swallow its response
module ifu_fetch #(
    parameter int ADDR_W      = 32,
    parameter int INST_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_we,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_fault,
    output logic [31:0]       fetch_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] DROP = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              drop_pend;
    logic              fire;
    logic              accept;
    logic              misaligned;

    assign misaligned     = ALIGN_CHECK && (pc_in[1:0] != 2'b00);
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;
    assign fire           = imem_req_valid & imem_req_ready;
    assign inst_valid     = (state == HOLD);
    assign accept         = inst_valid & inst_ready & ~flush;
    assign pc_we          = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            drop_pend   <= 1'b0;
            fetch_pc    <= '0;
            inst_out    <= '0;
            inst_pc     <= '0;
            inst_fault  <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fetch_pc <= pc_in;
                    if (misaligned) begin
                        inst_out   <= '0;
                        inst_fault <= 1'b1;
                        inst_pc    <= pc_in;
                        state      <= HOLD;
                    end else begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    // a flush cannot retract the request, so remember to drop its response
                    if (fire) begin
                        state <= (flush || drop_pend) ? DROP : WAIT;
                    end else if (flush) begin
                        drop_pend <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            inst_out   <= imem_rsp_data;
                            inst_fault <= imem_rsp_err;
                            inst_pc    <= fetch_pc;
                            state      <= HOLD;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (inst_ready) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        drop_pend <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    drop_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed walk through the fetch scenarios, then a randomized
// run against a PC-register / memory reference model that checks every delivered instruction.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_we;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] fetch_count;

    int n_pass  = 0;
    int n_total = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_we          (pc_we),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // inputs change just after the active edge, outputs are sampled mid-cycle
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[5:2] == 4'hf;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom & 32'h0000_0ffc;
        if ($urandom_range(0, 7) == 0) p[1] = 1'b1;
        return p;
    endfunction

    initial begin
        logic        pend;
        int          pend_cnt;
        logic [31:0] pend_addr;
        logic        prev_stall;
        logic [31:0] prev_addr;
        logic [31:0] pc_reg;
        logic [31:0] exp_out;
        logic        exp_flt;
        int          accepted;
        logic        fire;

        rst = 1'b1; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;

        // reset state
        go(); go(); look();
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_pc_we", pc_we, 1'b0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk1("rst_fault", inst_fault, 1'b0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_req_addr, 32'h0);

        // basic fetch at PC 0, then decode stalls for 5 HOLD cycles
        go(); rst = 1'b0; pc_in = 32'h0; imem_req_ready = 1'b1; look();
        chk1("idle_no_req", imem_req_valid, 1'b0);
        go(); look();
        chk1("req_valid", imem_req_valid, 1'b1);
        chk("req_addr", imem_req_addr, 32'h0);
        go(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013; look();
        go(); imem_rsp_valid = 1'b0; look();
        chk1("hold_valid", inst_valid, 1'b1);
        chk("hold_out", inst_out, 32'h0000_0013);
        chk("hold_pc", inst_pc, 32'h0);
        chk1("hold_fault", inst_fault, 1'b0);
        for (int i = 0; i < 4; i++) begin
            go(); look();
            chk1("stall_valid", inst_valid, 1'b1);
            chk("stall_out", inst_out, 32'h0000_0013);
            chk("stall_pc", inst_pc, 32'h0);
            chk1("stall_pc_we", pc_we, 1'b0);
        end
        chk("count_before_accept", fetch_count, 32'd0);
        go(); inst_ready = 1'b1; look();
        chk1("accept_pc_we", pc_we, 1'b1);

        // request stalled 3 cycles, bus error response
        go(); inst_ready = 1'b0; pc_in = 32'h8000_0004; imem_req_ready = 1'b0; look();
        chk1("pc_we_one_cycle", pc_we, 1'b0);
        chk1("valid_drops", inst_valid, 1'b0);
        chk("count_1", fetch_count, 32'd1);
        for (int i = 0; i < 3; i++) begin
            go(); look();
            chk1("stall_req_valid", imem_req_valid, 1'b1);
            chk("stall_req_addr", imem_req_addr, 32'h8000_0004);
        end
        go(); imem_req_ready = 1'b1; look();
        chk("fire_req_addr", imem_req_addr, 32'h8000_0004);
        go(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hdead_beef; imem_rsp_err = 1'b1; look();
        chk1("wait_no_req", imem_req_valid, 1'b0);
        go(); imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; look();
        chk1("err_valid", inst_valid, 1'b1);
        chk1("err_fault", inst_fault, 1'b1);
        chk("err_pc", inst_pc, 32'h8000_0004);
        chk("err_out", inst_out, 32'hdead_beef);
        go(); inst_ready = 1'b1; look();
        chk1("err_pc_we", pc_we, 1'b1);

        // flush in WAIT, stale response two cycles later
        go(); inst_ready = 1'b0; pc_in = 32'h8000_0008; imem_req_ready = 1'b1; look();
        chk("count_2", fetch_count, 32'd2);
        go(); look();
        chk1("f_wait_req", imem_req_valid, 1'b1);
        go(); flush = 1'b1; pc_in = 32'h0000_0100; look();
        go(); flush = 1'b0; look();
        go(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0bad_0bad; look();
        chk1("drop_no_valid", inst_valid, 1'b0);
        go(); imem_rsp_valid = 1'b0; look();
        chk1("drop_no_valid2", inst_valid, 1'b0);
        go(); look();
        chk1("redir_req", imem_req_valid, 1'b1);
        chk("redir_addr", imem_req_addr, 32'h0000_0100);
        go(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093; look();
        go(); imem_rsp_valid = 1'b0; look();
        chk1("redir_valid", inst_valid, 1'b1);
        chk("redir_out", inst_out, 32'h0010_0093);
        chk("redir_pc", inst_pc, 32'h0000_0100);
        chk("redir_count", fetch_count, 32'd2);

        // flush in REQ without acceptance, request taken a cycle later
        go(); inst_ready = 1'b1; look();
        go(); inst_ready = 1'b0; pc_in = 32'h0000_0104; imem_req_ready = 1'b0; look();
        chk("count_3", fetch_count, 32'd3);
        go(); flush = 1'b1; pc_in = 32'h0000_0200; look();
        chk("reqflush_addr", imem_req_addr, 32'h0000_0104);
        go(); flush = 1'b0; imem_req_ready = 1'b1; look();
        chk1("reqflush_still_req", imem_req_valid, 1'b1);
        chk("reqflush_still_addr", imem_req_addr, 32'h0000_0104);
        go(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0104; look();
        chk1("reqdrop_no_req", imem_req_valid, 1'b0);
        go(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; look();
        chk1("reqdrop_no_valid", inst_valid, 1'b0);
        go(); look();
        chk("reqdrop_next_addr", imem_req_addr, 32'h0000_0200);
        go(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0200; look();
        go(); imem_rsp_valid = 1'b0; look();
        chk("reqdrop_pc", inst_pc, 32'h0000_0200);

        // flush together with inst_ready in HOLD, redirect to a misaligned PC
        go(); flush = 1'b1; inst_ready = 1'b1; pc_in = 32'h0000_0002; look();
        chk1("hold_flush_pc_we", pc_we, 1'b0);
        go(); flush = 1'b0; inst_ready = 1'b0; look();
        chk1("hold_flush_valid", inst_valid, 1'b0);
        chk("hold_flush_count", fetch_count, 32'd3);
        go(); look();
        chk1("mis_no_req", imem_req_valid, 1'b0);
        chk1("mis_valid", inst_valid, 1'b1);
        chk1("mis_fault", inst_fault, 1'b1);
        chk("mis_out", inst_out, 32'h0);
        chk("mis_pc", inst_pc, 32'h0000_0002);
        go(); inst_ready = 1'b1; look();
        chk1("mis_pc_we", pc_we, 1'b1);

        // reset while WAITing, late response afterwards
        go(); inst_ready = 1'b0; pc_in = 32'h0000_0010; look();
        chk("count_4", fetch_count, 32'd4);
        go(); look();
        chk1("rw_req", imem_req_valid, 1'b1);
        go(); rst = 1'b1; look();
        go(); rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0bad_f00d; look();
        chk1("rw_inst_valid", inst_valid, 1'b0);
        chk1("rw_req_valid", imem_req_valid, 1'b0);
        chk("rw_count", fetch_count, 32'h0);
        chk("rw_out", inst_out, 32'h0);
        chk("rw_pc", inst_pc, 32'h0);
        chk("rw_addr", imem_req_addr, 32'h0);
        go(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; look();
        chk1("late_rsp_ignored", inst_valid, 1'b0);
        chk1("late_rsp_req", imem_req_valid, 1'b1);

        // randomized run against the PC-register / memory model
        pc_reg = rand_pc();
        go(); rst = 1'b1; pc_in = pc_reg;
        go(); rst = 1'b0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        prev_stall = 1'b0; prev_addr = '0; accepted = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc != 0) go();
            imem_rsp_valid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(pend_addr);
                    imem_rsp_err   = mem_err(pend_addr);
                end else begin
                    pend_cnt--;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            if (flush) pc_reg = rand_pc();
            pc_in          = pc_reg;
            imem_req_ready = ($urandom_range(0, 9) < 7);
            inst_ready     = $urandom_range(0, 1) == 1;
            look();

            if (prev_stall) begin
                chk1("rnd_req_held", imem_req_valid, 1'b1);
                chk("rnd_addr_held", imem_req_addr, prev_addr);
            end
            fire = imem_req_valid & imem_req_ready;
            if (fire) chk1("rnd_single_outstanding", pend, 1'b0);
            if (imem_rsp_valid) pend = 1'b0;
            if (fire) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_cnt  = $urandom_range(0, 3);
            end
            if (flush) chk1("rnd_flush_no_pc_we", pc_we, 1'b0);
            if (pc_we) begin
                if (pc_reg[1:0] != 2'b00) begin
                    exp_out = '0;
                    exp_flt = 1'b1;
                end else begin
                    exp_out = mem_data(pc_reg);
                    exp_flt = mem_err(pc_reg);
                end
                chk("rnd_inst_pc", inst_pc, pc_reg);
                chk("rnd_inst_out", inst_out, exp_out);
                chk1("rnd_inst_fault", inst_fault, exp_flt);
                accepted++;
                pc_reg = pc_reg + 32'd4;
            end
            prev_stall = imem_req_valid & ~imem_req_ready;
            prev_addr  = imem_req_addr;
        end
        go(); flush = 1'b0; inst_ready = 1'b0; imem_rsp_valid = 1'b0; look();
        chk("rnd_fetch_count", fetch_count, accepted);
        chk1("rnd_progress", accepted > 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly downstream of the PC register. Samples the current PC and issues a single-outstanding request to instruction memory over a valid/ready channel. Holds the returned instruction on a valid/ready output to decode. Pulses an advance enable back to the PC register once decode accepts the instruction. Supports flush/redirect with correct discard of an in-flight response.

Parameters:
ADDR_W, 32, address and PC width
INST_W, 32, instruction width
ALIGN_CHECK, 1, 1 = PC[1:0]!=0 raises a fault with no memory request; 0 = no check

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
pc_in  input  ADDR_W  current PC from the PC register
pc_we  output  1  advance enable to the PC register; PC loads its next value at the same edge
flush  input  1  redirect; discard current fetch
imem_req_valid  output  1  memory request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  request address
imem_rsp_valid  input  1  memory response valid (always accepted)
imem_rsp_data  input  INST_W  response instruction
imem_rsp_err  input  1  response bus error
inst_valid  output  1  instruction valid to decode
inst_ready  input  1  decode accepts
inst_out  output  INST_W  instruction
inst_pc  output  ADDR_W  PC of inst_out
inst_fault  output  1  misaligned or bus-error fetch
fetch_count  output  32  count of instructions accepted by decode

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; drop_pend=0.
  - Outputs: imem_req_valid=0, inst_valid=0, pc_we=0, inst_out=0, inst_pc=0, inst_fault=0, fetch_count=0, imem_req_addr=0.
  - Reset mid-transaction abandons it. Any response arriving after reset is ignored, because IDLE ignores imem_rsp_valid.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - Latch fetch_pc<=pc_in.
  - If ALIGN_CHECK and pc_in[1:0]!=0: go to HOLD with inst_out=0, inst_fault=1, inst_pc=pc_in.
  - Otherwise go to REQ.
  - flush in IDLE has no effect.
- REQ:
  - imem_req_valid=1, imem_req_addr=fetch_pc.
  - The request is never retracted; addr is stable until accepted.
  - fire = imem_req_valid & imem_req_ready. On fire go to WAIT, or to DROP if flush is active this cycle or drop_pend=1.
  - flush without fire sets drop_pend=1.
- WAIT:
  - On imem_rsp_valid: inst_out<=imem_rsp_data, inst_fault<=imem_rsp_err, inst_pc<=fetch_pc, then go to HOLD.
  - flush with no response: go to DROP.
  - flush and response in the same cycle: discard the response, go to IDLE.
- DROP: wait for imem_rsp_valid, discard it, clear drop_pend, go to IDLE. flush is ignored here.
- HOLD:
  - inst_valid=1; inst_out, inst_pc and inst_fault are stable until accepted.
  - Accept = inst_valid & inst_ready & ~flush. On accept:
    - pc_we=1 for exactly that cycle (combinational).
    - fetch_count += 1, wrapping 0xFFFFFFFF to 0.
    - Go to IDLE.
  - flush (including flush together with inst_ready): inst_valid deasserts next cycle, pc_we=0, no count, go to IDLE.
- pc_we is asserted only in the HOLD accept cycle. The redirect PC load is the core's responsibility while flush is active.
- Latency: accept-to-next inst_valid is at least 4 cycles with zero-wait memory:
  - IDLE, REQ (ready=1), WAIT (rsp same cycle as entry), HOLD.
  - Each memory wait cycle adds one cycle.
- At most one outstanding request. imem_req_valid=0 in every state except REQ.
- Faulted instruction (either source) follows the normal HOLD/accept path, and pc_we still pulses.

Test Plan:
- Reset then pc_in=0x00000000, req_ready=1, rsp 1 cycle after accept with data=0x00000013 -> req_addr=0x0, inst_valid with inst_out=0x00000013, inst_pc=0, fault=0. With inst_ready=1: pc_we pulses for 1 cycle and fetch_count=1.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid, inst_out and inst_pc stable. pc_we stays 0 until ready=1, then exactly one pulse.
- req_ready=0 for 3 cycles with pc_in=0x80000004 -> req_valid=1 and addr=0x80000004 constant, then accepted. A response with imem_rsp_err=1 gives inst_fault=1, inst_pc=0x80000004.
- flush during WAIT, response arrives 2 cycles later -> no inst_valid for that response. Next request uses the new pc_in=0x00000100 and fetch_count is unchanged.
- flush in REQ while req_ready=0, accepted next cycle -> DROP entered, response discarded. flush together with inst_ready in HOLD -> pc_we=0 and count is unchanged.
- ALIGN_CHECK=1, pc_in=0x00000002 -> no imem_req_valid. inst_valid with inst_fault=1, inst_out=0, inst_pc=0x2. Reset asserted mid-WAIT -> all outputs return to zero next cycle and the late response is ignored.
